// File: rtl/reg_scoreboard.sv
// Decode-side register scoreboard: per-register in-flight write counters that stall issue on RAW hazards
// and on write-counter saturation. Optional stall statistics under SCOREBOARD_STATS_EN.
module reg_scoreboard #(
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16,
  parameter int CNT_WIDTH  = 2,
  parameter int PC_ADDR    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  issue_valid_i,
  input  logic [2:0]            src_used_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_1_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_2_i,
  input  logic [ADDR_WIDTH-1:0] src_addr_3_i,
  input  logic                  dest_valid_i,
  input  logic [ADDR_WIDTH-1:0] dest_addr_i,
  input  logic                  retire_valid_i,
  input  logic [ADDR_WIDTH-1:0] retire_addr_i,
  output logic                  stall_o,
  output logic                  issue_accept_o,
  output logic [NUM_REGS-1:0]   pending_mask_o,
  output logic                  underflow_err_o
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           waw_stall_cycles_o
`endif
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PC      = ADDR_WIDTH'(PC_ADDR);

  logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  logic                  underflow_q, underflow_d;
  logic [NUM_REGS-1:0]   ret_hit, eff_nz, eff_max, inc, dec;
  logic [ADDR_WIDTH-1:0] src_addr [3];
  logic                  raw_stall, waw_stall, stall, accept;

  assign src_addr[0] = src_addr_1_i;
  assign src_addr[1] = src_addr_2_i;
  assign src_addr[2] = src_addr_3_i;

  // A retiring producer is already resolved for this cycle's hazard checks
  // because the register file forwards the same-cycle write.
  always_comb begin
    ret_hit = '0;
    eff_nz  = '0;
    eff_max = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      ret_hit[r] = retire_valid_i && (retire_addr_i == ADDR_WIDTH'(r));
      eff_nz[r]  = (cnt_q[r] > CNT_ONE) || ((cnt_q[r] == CNT_ONE) && !ret_hit[r]);
      eff_max[r] = (cnt_q[r] == CNT_MAX) && !ret_hit[r];
    end
  end

  always_comb begin
    raw_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (src_used_i[k] && (src_addr[k] != PC) && eff_nz[src_addr[k]]) raw_stall = 1'b1;
    end
    waw_stall = dest_valid_i && (dest_addr_i != PC) && eff_max[dest_addr_i];
    stall     = issue_valid_i && (raw_stall || waw_stall);
    accept    = issue_valid_i && !stall;
  end

  assign stall_o        = stall;
  assign issue_accept_o = accept;

  always_comb begin
    underflow_d = underflow_q;
    pending_d   = '0;
    inc         = '0;
    dec         = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc[r]   = accept && dest_valid_i && (dest_addr_i == ADDR_WIDTH'(r)) && (r != PC_ADDR);
      dec[r]   = ret_hit[r] && (r != PC_ADDR);
      cnt_d[r] = cnt_q[r];
      if (inc[r] && !dec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec[r] && !inc[r]) begin
        if (cnt_q[r] == '0) underflow_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
      pending_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      pending_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      pending_q   <= pending_d;
      underflow_q <= underflow_d;
    end
  end

  assign pending_mask_o  = pending_q;
  assign underflow_err_o = underflow_q;

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] waw_cycles_q, waw_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q + 32'(stall);
    waw_cycles_d   = waw_cycles_q + 32'(issue_valid_i && waw_stall && !raw_stall);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stall_cycles_q <= '0;
      waw_cycles_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      waw_cycles_q   <= waw_cycles_d;
    end
  end

  assign stall_cycles_o     = stall_cycles_q;
  assign waw_stall_cycles_o = waw_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed-vector bench for reg_scoreboard; the driver queues hand-computed expectations and a
// negedge monitor pops and compares them against the DUT outputs.
module tb_reg_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        issue_valid_i = 1'b0;
  logic [2:0]  src_used_i = '0;
  logic [3:0]  src_addr_1_i = '0, src_addr_2_i = '0, src_addr_3_i = '0;
  logic        dest_valid_i = 1'b0;
  logic [3:0]  dest_addr_i = '0;
  logic        retire_valid_i = 1'b0;
  logic [3:0]  retire_addr_i = '0;
  logic        stall_o, issue_accept_o, underflow_err_o;
  logic [15:0] pending_mask_o;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_o, waw_stall_cycles_o;
`endif

  reg_scoreboard dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .issue_valid_i  (issue_valid_i),
    .src_used_i     (src_used_i),
    .src_addr_1_i   (src_addr_1_i),
    .src_addr_2_i   (src_addr_2_i),
    .src_addr_3_i   (src_addr_3_i),
    .dest_valid_i   (dest_valid_i),
    .dest_addr_i    (dest_addr_i),
    .retire_valid_i (retire_valid_i),
    .retire_addr_i  (retire_addr_i),
    .stall_o        (stall_o),
    .issue_accept_o (issue_accept_o),
    .pending_mask_o (pending_mask_o),
    .underflow_err_o(underflow_err_o)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles_o    (stall_cycles_o),
    .waw_stall_cycles_o(waw_stall_cycles_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    bit          stall;
    bit          acc;
    logic [15:0] mask;
    bit          uf;
    bit          chk_state;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  // rst, iv, used, s1, s2, s3, dv, da, rv, ra | expected stall, accept, mask, underflow, check-state flag
  task automatic vec(input bit rst, input bit iv, input logic [2:0] used,
                     input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3,
                     input bit dv, input logic [3:0] da, input bit rv, input logic [3:0] ra,
                     input bit e_stall, input bit e_acc, input logic [15:0] e_mask,
                     input bit e_uf, input bit cs);
    exp_t e;
    @(posedge clk_i);
    #1;
    rst_n_i = rst; issue_valid_i = iv; src_used_i = used;
    src_addr_1_i = s1; src_addr_2_i = s2; src_addr_3_i = s3;
    dest_valid_i = dv; dest_addr_i = da; retire_valid_i = rv; retire_addr_i = ra;
    e.idx = vec_idx; e.stall = e_stall; e.acc = e_acc; e.mask = e_mask; e.uf = e_uf; e.chk_state = cs;
    exp_q.push_back(e);
    vec_idx++;
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (stall_o !== e.stall) begin
        errors++;
        $display("FAIL stall vec%0d: got %b expected %b", e.idx, stall_o, e.stall);
      end
      checks++;
      if (issue_accept_o !== e.acc) begin
        errors++;
        $display("FAIL accept vec%0d: got %b expected %b", e.idx, issue_accept_o, e.acc);
      end
      if (e.chk_state) begin
        checks++;
        if (pending_mask_o !== e.mask) begin
          errors++;
          $display("FAIL pending_mask vec%0d: got %h expected %h", e.idx, pending_mask_o, e.mask);
        end
        checks++;
        if (underflow_err_o !== e.uf) begin
          errors++;
          $display("FAIL underflow vec%0d: got %b expected %b", e.idx, underflow_err_o, e.uf);
        end
      end
    end
  end

  initial begin
    int budget;
    // reset then idle
    vec(0,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,0);
    vec(0,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    // RAW stall on r3 released by same-cycle retire
    vec(1,1,3'b000,0,0,0, 1,3, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b001,3,0,0, 0,0, 0,0,  1,0,16'h0008,0,1);
    vec(1,1,3'b001,3,0,0, 0,0, 0,0,  1,0,16'h0008,0,1);
    vec(1,1,3'b001,3,0,0, 0,0, 0,0,  1,0,16'h0008,0,1);
    vec(1,1,3'b001,3,0,0, 0,0, 1,3,  0,1,16'h0008,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    // same-cycle issue and retire on r5 keeps cnt[5] at 1
    vec(1,1,3'b000,0,0,0, 1,5, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b001,1,0,0, 1,5, 1,5,  0,1,16'h0020,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0020,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 1,5,  0,0,16'h0020,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    // WAW saturation on r2
    vec(1,1,3'b000,0,0,0, 1,2, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b000,0,0,0, 1,2, 0,0,  0,1,16'h0004,0,1);
    vec(1,1,3'b000,0,0,0, 1,2, 0,0,  0,1,16'h0004,0,1);
    vec(1,1,3'b000,0,0,0, 1,2, 0,0,  1,0,16'h0004,0,1);
    vec(1,1,3'b000,0,0,0, 1,2, 1,2,  0,1,16'h0004,0,1);
    vec(1,1,3'b000,0,0,0, 1,2, 0,0,  1,0,16'h0004,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 1,2,  0,0,16'h0004,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 1,2,  0,0,16'h0004,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 1,2,  0,0,16'h0004,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    // self read/write of r4, duplicate sources, used-mask gating, issue_valid gating
    vec(1,1,3'b111,4,4,4, 1,4, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b110,4,6,6, 0,0, 0,0,  0,1,16'h0010,0,1);
    vec(1,0,3'b001,4,0,0, 0,0, 0,0,  0,0,16'h0010,0,1);
    vec(1,1,3'b100,0,0,4, 0,0, 0,0,  1,0,16'h0010,0,1);
    vec(1,1,3'b010,0,4,0, 0,0, 1,4,  0,1,16'h0010,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    // PC exemption
    vec(1,1,3'b111,15,15,15, 1,15, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b111,15,15,15, 1,15, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b111,15,15,15, 1,15, 0,0,  0,1,16'h0000,0,1);
    vec(1,1,3'b111,15,15,15, 1,15, 1,15, 0,1,16'h0000,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    // underflow on r7, sticky until reset; reset dominates a concurrent issue
    vec(1,0,3'b000,0,0,0, 0,0, 1,7,  0,0,16'h0000,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,1,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,1,1);
    vec(0,1,3'b000,0,0,0, 1,8, 0,0,  0,1,16'h0000,1,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);
    vec(1,0,3'b000,0,0,0, 0,0, 0,0,  0,0,16'h0000,0,1);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clk_i);
      budget++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Decode-side hazard tracker that sits directly upstream of the clocked register file and gates instruction issue into the register-read stage.
- Keeps a per-register count of in-flight writes that have been issued but have not yet retired.
- Stalls decode while any source operand still has an unresolved producer.
- A source whose last producer writes back in the same cycle is allowed to issue, because the register file forwards a same-cycle write to its read outputs one cycle later.

Parameters:
- ADDR_WIDTH, 4, register address width.
- NUM_REGS, 16, number of architectural registers tracked (equals 2**ADDR_WIDTH).
- CNT_WIDTH, 2, width of each per-register pending counter.
- PC_ADDR, 15, register index that is never tracked and never stalls.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_n_i  in  1  reset, synchronous, active-low.
- issue_valid_i  in  1  decode presents an instruction this cycle.
- src_used_i  in  3  per-source valid mask; bit k qualifies src_addr_(k+1)_i.
- src_addr_1_i  in  ADDR_WIDTH  source register 1.
- src_addr_2_i  in  ADDR_WIDTH  source register 2.
- src_addr_3_i  in  ADDR_WIDTH  source register 3.
- dest_valid_i  in  1  the presented instruction writes a register.
- dest_addr_i  in  ADDR_WIDTH  destination register.
- retire_valid_i  in  1  an instruction with a destination leaves write-back this cycle; asserted even if the instruction was squashed and its write is suppressed.
- retire_addr_i  in  ADDR_WIDTH  destination of the retiring instruction.
- stall_o  out  1  combinational; decode must hold the current instruction.
- issue_accept_o  out  1  combinational; equals issue_valid_i & ~stall_o.
- pending_mask_o  out  NUM_REGS  registered; bit r is set when cnt[r] != 0.
- underflow_err_o  out  1  sticky; set when a retire arrives for a register with no pending write.

Behaviour:
- State is one counter per register, cnt[r], CNT_WIDTH bits wide. Counter saturation limit is MAX = 2**CNT_WIDTH - 1.
- Reset (rst_n_i = 0 at a clock edge): all cnt = 0, pending_mask_o = 0, underflow_err_o = 0. Reset dominates every other input in that cycle.
- Effective pending count: eff[r] = cnt[r] - ((retire_valid_i && retire_addr_i == r) ? 1 : 0). This is combinational and floors at 0.
- RAW stall: some k with src_used_i[k] = 1, src_addr_k != PC_ADDR, and eff[src_addr_k] != 0.
- WAW saturation stall: dest_valid_i = 1, dest_addr_i != PC_ADDR, and eff[dest_addr_i] == MAX.
- stall_o is the OR of the RAW and WAW stall conditions, gated by issue_valid_i. stall_o = 0 when issue_valid_i = 0.
- Counter update each cycle, let inc = issue_accept_o && dest_valid_i && dest_addr_i == r && r != PC_ADDR, and dec = retire_valid_i && retire_addr_i == r:
  - inc & ~dec: cnt + 1.
  - dec & ~inc: cnt - 1.
  - inc & dec: unchanged.
  - neither: unchanged.
- Underflow: dec while cnt[r] == 0 and no inc to the same register. cnt stays 0 and underflow_err_o is set; it clears only on reset.
- Retire of PC_ADDR is ignored and is not an error.
- pending_mask_o reflects the counters after the update, with 1-cycle latency from issue or retire.
- Issue-to-visible latency: an instruction accepted in cycle N makes its destination stall dependents from cycle N+1.
- The same instruction reading and writing the same register is checked against the pre-issue count only, so it does not self-stall.
- Multiple source fields naming the same register are legal and produce no additional effect.
- Squashed instructions still retire, which keeps the counters consistent; there is no separate flush port.

Optional Feature:
- Macro: SCOREBOARD_STATS_EN.
- Defined:
  - Adds output stall_cycles_o, 32 bits.
  - Counts cycles with stall_o = 1, wraps modulo 2**32, and resets to 0.
  - Adds output waw_stall_cycles_o, 32 bits, counting cycles where the WAW saturation term alone causes the stall.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then idle: rst_n_i = 0 for 2 cycles -> pending_mask_o = 0x0000, stall_o = 0, underflow_err_o = 0.
- RAW stall: cycle 0 issue with dest r3; cycle 1 issue using src r3 -> stall_o = 1 and pending_mask_o = 0x0008. stall_o stays 1 until retire_valid_i with retire_addr_i = 3 arrives at cycle 4; issue_accept_o = 1 in cycle 4, and pending_mask_o = 0x0000 in cycle 5.
- Same-cycle issue and retire on r5, with cnt[5] = 1 and the new instruction writing r5 and reading r1 -> accepted, cnt[5] remains 1, pending_mask_o bit 5 remains set.
- WAW saturation: issue 3 writes to r2 with no retires -> the 4th write to r2 stalls. Retire one r2 in the same cycle -> the 4th issues, and cnt[2] stays 3.
- PC exemption: source = r15 and dest = r15 repeatedly -> stall_o always 0 and pending_mask_o bit 15 always 0.
- Underflow: retire r7 with cnt[7] = 0 -> underflow_err_o = 1 from the next cycle and stays 1; cnt[7] = 0. A later reset clears it.
